pcileech_dna_check: RTL

- Reads the 57-bit Artix-7 device DNA through the DNA_PORT primitive and compares it against a build-time expected value.
- Produces a latched match verdict and a communication-enable output; the top level uses the enable to gate the FT601 path.
- Sits between the DNA_PORT primitive (upstream) and the top-level FT601 enable logic (downstream).
- Runs once after reset. Outputs are static once resolved.

---
 rtl/pcileech_dna_pkg.sv | 22 ++
 rtl/pcileech_dna_check_if.sv | 10 +
 rtl/pcileech_dna_clkgen.sv | 40 ++++
 rtl/pcileech_dna_check.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/pcileech_dna_pkg.sv
// Shared types for the device-DNA check block: DNA width, DNA value type and FSM states.
package pcileech_dna_pkg;

  localparam int DNA_WIDTH = 57;

  typedef logic [DNA_WIDTH-1:0] dna_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    COMPARE,
    DONE,
    FAIL
  } dna_state_t;

  // DONE and FAIL are sticky until reset; the divider is parked there.
  function automatic logic is_terminal(input dna_state_t s);
    return (s == DONE) || (s == FAIL);
  endfunction

endpackage

// File: rtl/pcileech_dna_check_if.sv
// Pin bundle between the DNA check block (master) and the DNA_PORT primitive (slave).
interface pcileech_dna_check_if;
  logic dna_clk;
  logic dna_read;
  logic dna_shift;
  logic dna_dout;

  modport master (output dna_clk, output dna_read, output dna_shift, input  dna_dout);
  modport slave  (input  dna_clk, input  dna_read, input  dna_shift, output dna_dout);
endinterface

// File: rtl/pcileech_dna_clkgen.sv
// Divided DNA_PORT clock with single-cycle rise/fall strobes marking the clk cycle
// in which dna_clk toggles. Disabling parks the divider with dna_clk low.
module pcileech_dna_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_dna_clk,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;
  logic       r_clk;
  logic       w_edge;

  assign w_edge    = i_en && (r_cnt == DIV_M1);
  assign o_rise    = w_edge && !r_clk;
  assign o_fall    = w_edge &&  r_clk;
  assign o_dna_clk = r_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_clk <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_clk <= 1'b0;
    end else if (w_edge) begin
      r_cnt <= '0;
      r_clk <= ~r_clk;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/pcileech_dna_check.sv
// Reads the 57-bit device DNA twice per attempt, confirms agreeing reads and compares
// against EXPECTED_DNA. Define PCILEECH_DNA_ENFORCE_EN to gate o_com_en on a match.
module pcileech_dna_check
  import pcileech_dna_pkg::*;
#(
  parameter logic [56:0] EXPECTED_DNA = 57'h0,
  parameter int          CLK_DIV      = 4,
  parameter int          MAX_RETRY    = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pcileech_dna_check_if.master         dna,
  output dna_t                         o_dna,
  output logic                         o_dna_valid,
  output logic                         o_id_match,
  output logic                         o_fail,
  output logic                         o_com_en
);

  dna_state_t r_state;
  logic       r_read, r_shift, r_second, r_armed;
  logic [5:0] r_bit;
  logic [3:0] r_pair;
  dna_t       r_sr, r_hold, r_dna;
  logic       r_valid, r_match, r_fail, r_com_en;

  logic       w_rise, w_fall, w_clk_en;
  logic [3:0] w_pair_nxt;

  assign w_clk_en   = !is_terminal(r_state);
  assign w_pair_nxt = r_pair + 4'd1;

  pcileech_dna_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_clk_en),
    .o_dna_clk (dna.dna_clk),
    .o_rise    (w_rise),
    .o_fall    (w_fall)
  );

  assign dna.dna_read  = r_read;
  assign dna.dna_shift = r_shift;
  assign o_dna         = r_dna;
  assign o_dna_valid   = r_valid;
  assign o_id_match    = r_match;
  assign o_fail        = r_fail;
  assign o_com_en      = r_com_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_read   <= 1'b0;
      r_shift  <= 1'b0;
      r_second <= 1'b0;
      r_armed  <= 1'b0;
      r_bit    <= '0;
      r_pair   <= '0;
      r_sr     <= '0;
      r_hold   <= '0;
      r_dna    <= '0;
      r_valid  <= 1'b0;
      r_match  <= 1'b0;
      r_fail   <= 1'b0;
      r_com_en <= 1'b0;
    end else begin
      unique case (r_state)
        // Wait for one full high phase of dna_clk before driving READ.
        IDLE: begin
          if (w_rise) r_armed <= 1'b1;
          if (w_fall && r_armed) begin
            r_read  <= 1'b1;
            r_state <= LOAD;
          end
        end
        // After a retry READ is still low: raise it first, sample on the next fall.
        LOAD: begin
          if (w_fall) begin
            if (!r_read) begin
              r_read <= 1'b1;
            end else begin
              r_sr[56] <= dna.dna_dout;
              r_read   <= 1'b0;
              r_shift  <= 1'b1;
              r_bit    <= 6'd55;
              r_state  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (w_fall) begin
            r_sr[r_bit] <= dna.dna_dout;
            if (r_bit == 6'd0) begin
              r_shift <= 1'b0;
              if (!r_second) begin
                // Bit 0 lands in r_sr only at this edge, so fold it in directly.
                r_hold   <= {r_sr[56:1], dna.dna_dout};
                r_second <= 1'b1;
                r_read   <= 1'b1;
                r_state  <= LOAD;
              end else begin
                r_second <= 1'b0;
                r_state  <= COMPARE;
              end
            end else begin
              r_bit <= r_bit - 6'd1;
            end
          end
        end
        COMPARE: begin
          if (r_hold == r_sr) begin
            r_dna   <= r_sr;
            r_valid <= 1'b1;
            r_match <= (r_sr == EXPECTED_DNA);
            r_state <= DONE;
          end else begin
            r_pair <= w_pair_nxt;
            if (w_pair_nxt == 4'(MAX_RETRY)) begin
              r_fail  <= 1'b1;
              r_state <= FAIL;
            end else begin
              r_state <= LOAD;
            end
          end
        end
        DONE, FAIL: begin
          r_read  <= 1'b0;
          r_shift <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase

`ifdef PCILEECH_DNA_ENFORCE_EN
      r_com_en <= (r_state == DONE) && r_match;
`else
      r_com_en <= is_terminal(r_state);
`endif
    end
  end

endmodule
